// File: rtl/sha_arbiter.sv
// Two-requester arbiter in front of a single SHA-256 core: round-robin grant,
// one start pulse per service, digest capture on core_valid rise, abort on timeout.
//
// state | meaning
// IDLE  | no service; waits for a request while the core is quiet
// START | core_start high for one cycle, counter cleared
// WAIT  | counting towards TIMEOUT, watching for core_valid rising
// DONE  | done (and err on abort) pulse to the granted requester
// DRAIN | waits for core_valid low before accepting new work
module sha_arbiter #(
  parameter int TIMEOUT = 96
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req0,
  input  logic         req1,
  input  logic [511:0] msg0,
  input  logic [511:0] msg1,
  output logic         grant0,
  output logic         grant1,
  output logic         done0,
  output logic         done1,
  output logic [255:0] digest,
  output logic         err,
  output logic         busy,
  output logic         core_start,
  output logic [511:0] core_message,
  input  logic [255:0] core_hashvalue,
  input  logic         core_valid
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, DRAIN} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state;
  logic       rr;
  logic       abort;
  logic       valid_d;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       valid_rise;
  logic       pick1;

  assign cnt_inc    = (cnt == 8'hff) ? cnt : cnt + 8'd1;
  assign valid_rise = core_valid & ~valid_d;
  // rr high means requester 1 has priority when both are asking
  assign pick1      = req1 & (~req0 | rr);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      rr           <= 1'b0;
      abort        <= 1'b0;
      valid_d      <= 1'b0;
      cnt          <= 8'd0;
      grant0       <= 1'b0;
      grant1       <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      core_start   <= 1'b0;
      digest       <= '0;
      core_message <= '0;
    end else begin
      valid_d <= core_valid;
      case (state)
        IDLE: begin
          if ((req0 | req1) && !core_valid) begin
            grant0       <= ~pick1;
            grant1       <= pick1;
            core_message <= pick1 ? msg1 : msg0;
            core_start   <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          core_start <= 1'b0;
          cnt        <= 8'd0;
          state      <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (valid_rise) begin
            digest <= core_hashvalue;
            done0  <= grant0;
            done1  <= grant1;
            state  <= DONE;
          end else if (cnt_inc >= TO) begin
            // err rises with done so the requester sees both in the same cycle
            abort <= 1'b1;
            err   <= 1'b1;
            done0 <= grant0;
            done1 <= grant1;
            state <= DONE;
          end
        end
        DONE: begin
          done0  <= 1'b0;
          done1  <= 1'b0;
          err    <= 1'b0;
          rr     <= grant0;
          grant0 <= 1'b0;
          grant1 <= 1'b0;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (!core_valid) begin
            abort <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha_arbiter.md
SHA_ARBITER -- requirements
Module: sha_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 96, max cycles from core_start to core_valid rising edge before abort.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  requester service request, level, held until the matching done pulse.
REQ-005 SHALL have ports msg0, msg1  input  512 each  padded message block; stable while the matching req is high.
REQ-006 SHALL have ports grant0, grant1  output  1 each  high while that requester is being served.
REQ-007 SHALL have ports done0, done1  output  1 each  one-cycle completion pulse to that requester.
REQ-008 SHALL have port digest  output  256  last captured hash; holds until the next capture.
REQ-009 SHALL have port err  output  1  one-cycle pulse, coincident with done, when a service aborted on timeout.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port core_start  output  1  single-cycle start pulse to the hash core.
REQ-012 SHALL have port core_message  output  512  registered block presented to the core.
REQ-013 SHALL have ports core_hashvalue (input, 256, core result) and core_valid (input, 1, core result-valid).

Function
REQ-014 SHALL implement states IDLE, START, WAIT, DONE, DRAIN.
REQ-015 IDLE: SHALL leave on a cycle where (req0|req1) and core_valid==0; it SHALL stay in IDLE while core_valid==1.
REQ-016 Grant: SHALL pick one winner on leaving IDLE.
- only one request -> that requester wins.
- both requesting -> winner is the requester indicated by round-robin pointer rr (reset 0 = req0 first).
REQ-017 On leaving IDLE, SHALL latch the winner's msg into core_message and set its grant; go to START.
REQ-018 START: SHALL assert core_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-019 WAIT: SHALL increment the timeout counter each cycle.
- on a core_valid rising edge (core_valid & ~valid_d, valid_d a registered copy): capture core_hashvalue into digest, go to DONE.
- otherwise, when the counter reaches TIMEOUT: leave digest unchanged, set an abort flag, go to DONE.
REQ-020 DONE (one cycle): SHALL pulse done of the granted requester, pulse err if the abort flag is set, and clear that grant.
- rr SHALL point to the other requester.
- SHALL go to DRAIN.
REQ-021 DRAIN: SHALL wait until core_valid==0, clear the abort flag, and return to IDLE; a new grant is therefore never issued while the core is still finishing.
REQ-022 Exactly one grant SHALL be high at a time; grants, done pulses and core_start SHALL be registered outputs.
REQ-023 If req drops mid-service, the service SHALL still complete and the done pulse SHALL still be issued; the arbiter ignores req outside IDLE.
REQ-024 Arbitration order SHALL be independent of request arrival order within the same cycle; starvation bound is one service per competing requester.
REQ-025 The timeout counter SHALL be 8 bits and saturate; with TIMEOUT=96 and a nominal core, the capture occurs well before abort.

Reset
REQ-026 While clr==0, the following SHALL be forced low/zero:
- state=IDLE, rr=0, abort flag=0, counter=0, valid_d=0;
- grant0, grant1, done0, done1, err, busy, core_start=0;
- digest=0, core_message=0.
REQ-027 clr assertion mid-service SHALL abandon the service immediately with no done pulse; after release, operation resumes from IDLE.

Verification
REQ-028 req0 with msg0 = "abc" block (word0 61626380, words1-14 0, word15 00000018) -> one core_start; then done0 pulses with digest ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad and err=0.
REQ-029 req0 and req1 raised in the same cycle after reset -> grant0 first, done0; then grant1, done1; never both grants high.
REQ-030 Core model never asserts core_valid -> done pulses with err=1 exactly TIMEOUT+1 cycles after core_start; digest is unchanged.
REQ-031 core_valid held high during IDLE with req1 pending -> no core_start until core_valid falls.
REQ-032 clr pulsed low during WAIT -> all outputs return to zero; no done pulse; a fresh req0 then completes normally.
REQ-033 req1 deasserted during WAIT -> done1 still pulses once, digest is updated, and the arbiter returns to IDLE.
